// File: rtl/tcdm_varlat_pkg.sv
// Shared types and helpers for the variable-latency TCDM crossbar.
// Used by both the bank-side arbiter and the master-side decoder.
package tcdm_varlat_pkg;

  function automatic int unsigned log_num_in(int unsigned n);
    int unsigned r;
    r = 1;
    if (n > 1) r = $clog2(n);
    return r;
  endfunction

  localparam int unsigned DfltNumIn = 4;

  typedef logic [log_num_in(DfltNumIn)-1:0] mst_id_t;

endpackage

// File: rtl/tcdm_bank_arb_varlat_if.sv
// Request/response bundle for N masters sharing one responder.
// With N=1 it models the single bank port.
interface tcdm_bank_arb_varlat_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 32
);
  logic [N-1:0]         req;
  logic [N-1:0][DW-1:0] data;
  logic [N-1:0]         gnt;
  logic [N-1:0]         vld;
  logic [RW-1:0]        rdata;

  modport master (
    output req, data,
    input  gnt, vld, rdata
  );

  modport slave (
    input  req, data,
    output gnt, vld, rdata
  );
endinterface

// File: rtl/tcdm_varlat_id_fifo.sv
// In-order FIFO of winner IDs for granted, unanswered requests.
// Registered storage, combinational head, no fall-through.
module tcdm_varlat_id_fifo
  import tcdm_varlat_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned PtrW  = log_num_in(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  function automatic logic [PtrW-1:0] inc(
    input logic [PtrW-1:0] p
  );
    if (p == PtrW'(DEPTH - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  always_comb begin
    wr_d  = push_i ? inc(wr_q) : wr_q;
    rd_d  = pop_i  ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + CntW'(push_i)
                  - CntW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/tcdm_bank_arb_varlat.sv
// Round-robin arbiter for one variable-latency TCDM bank.
// Winner IDs are queued so in-order responses return to their owner.
module tcdm_bank_arb_varlat
  import tcdm_varlat_pkg::*;
#(
  parameter  int unsigned NumIn          = 4,
  parameter  int unsigned ReqDataWidth   = 32,
  parameter  int unsigned RespDataWidth  = 32,
  parameter  int unsigned MaxOutstanding = 2,
  localparam int unsigned LogNumIn       = log_num_in(NumIn),
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  tcdm_bank_arb_varlat_if.slave mst_if,
  tcdm_bank_arb_varlat_if.master bank_if,
  output logic [CntW-1:0]       inflight_o,
  output logic                  err_o
);

  localparam logic [LogNumIn:0] NumInW =
    (LogNumIn + 1)'(NumIn);

  logic [LogNumIn-1:0] ptr_q, ptr_d;
  logic [LogNumIn-1:0] off, winner, head;
  logic [LogNumIn:0]   sum, nxt;
  logic [2*NumIn-1:0]  dbl;
  logic                any_req, can_issue;
  logic                full, empty;
  logic                push, pop, req_o;
  logic                gnt_i, vld_i;
  logic                err_q, err_d;

  assign gnt_i   = bank_if.gnt[0];
  assign vld_i   = bank_if.vld[0];
  assign any_req = |mst_if.req;

  // Rotate so ptr lands at bit 0; first set bit is the offset.
  always_comb begin
    dbl = {mst_if.req, mst_if.req} >> ptr_q;
    off = '0;
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (dbl[i]) off = LogNumIn'(i);
    end
  end

  always_comb begin
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= NumInW) sum = sum - NumInW;
    winner = sum[LogNumIn-1:0];
  end

  assign pop       = vld_i & ~empty;
  assign can_issue = ~full | pop;
  assign req_o     = any_req & can_issue;
  assign push      = req_o & gnt_i;

  always_comb begin
    nxt = {1'b0, winner} + 1'b1;
    if (nxt >= NumInW) nxt = '0;
    ptr_d = push ? nxt[LogNumIn-1:0] : ptr_q;
    err_d = err_q | (vld_i & empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  tcdm_varlat_id_fifo #(
    .DEPTH (MaxOutstanding),
    .WIDTH (LogNumIn)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (winner),
    .full_o  (full),
    .empty_o (empty),
    .count_o (inflight_o),
    .head_o  (head)
  );

  always_comb begin
    mst_if.gnt = '0;
    mst_if.vld = '0;
    mst_if.gnt[winner] = push;
    mst_if.vld[head]   = pop;
  end

  assign mst_if.rdata    = bank_if.rdata;
  assign bank_if.req[0]  = req_o;
  assign bank_if.data[0] = mst_if.data[winner];
  assign err_o           = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (NumIn > 0 && MaxOutstanding > 0);
      assert ($onehot0(mst_if.gnt));
      assert ($onehot0(mst_if.vld));
    end
  end

endmodule

// File: tb/tb_tcdm_bank_arb_varlat.sv
// Bench for tcdm_bank_arb_varlat: directed vector table plus
// random traffic against a queue-based reference model.
module tb_tcdm_bank_arb_varlat;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 32;
  localparam int MO = 2;
  localparam int CW = $clog2(MO + 1);

  logic clk = 1'b0;
  logic rst;
  logic [CW-1:0] inflight;
  logic err;
  logic [N-1:0][DW-1:0] dv;

  always #5 clk = ~clk;

  tcdm_bank_arb_varlat_if #(.N(N), .DW(DW), .RW(RW)) mst ();
  tcdm_bank_arb_varlat_if #(.N(1), .DW(DW), .RW(RW)) bank ();

  assign mst.data = dv;

  tcdm_bank_arb_varlat #(
    .NumIn          (N),
    .ReqDataWidth   (DW),
    .RespDataWidth  (RW),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mst_if     (mst),
    .bank_if    (bank),
    .inflight_o (inflight),
    .err_o      (err)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       gnt;
    logic       vld;
    logic [3:0] e_gnt;
    logic [3:0] e_vld;
    logic       e_req;
    logic [1:0] e_inf;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(logic r, logic [3:0] rq,
                       logic g, logic v,
                       logic [RW-1:0] rd);
    rst           = r;
    mst.req       = rq;
    bank.gnt[0]   = g;
    bank.vld[0]   = v;
    bank.rdata    = rd;
    for (int i = 0; i < N; i++) dv[i] = $urandom;
  endtask

  task automatic apply(string tag, vec_t v);
    logic [RW-1:0] rd;
    rd = $urandom;
    drive(v.rst, v.req, v.gnt, v.vld, rd);
    #4;
    check({tag, " gnt"}, 64'(mst.gnt), 64'(v.e_gnt));
    check({tag, " vld"}, 64'(mst.vld), 64'(v.e_vld));
    check({tag, " req"}, 64'(bank.req[0]), 64'(v.e_req));
    check({tag, " inf"}, 64'(inflight), 64'(v.e_inf));
    check({tag, " err"}, 64'(err), 64'(v.e_err));
    if (v.vld)
      check({tag, " rdata"}, 64'(mst.rdata), 64'(rd));
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int  mq[$];
  int  mptr;
  bit  merr;

  task automatic model_cycle(int c);
    logic          r, g, v;
    logic [3:0]    rq;
    logic [RW-1:0] rd;
    int            win;
    bit            canis, ereq, pop;
    logic [3:0]    egnt, evld;
    string         tag;
    tag = $sformatf("rnd%0d", c);
    r   = ($urandom_range(0, 59) == 0);
    rq  = 4'($urandom);
    g   = ($urandom_range(0, 3) != 0);
    v   = (mq.size() > 0) ? 1'($urandom)
                          : ($urandom_range(0, 99) == 0);
    rd  = $urandom;
    drive(r, rq, g, v, rd);
    #4;
    win = -1;
    for (int k = 0; k < N; k++) begin
      if (win < 0 && rq[(mptr + k) % N]) win = (mptr + k) % N;
    end
    pop   = v && mq.size() > 0;
    canis = (mq.size() < MO) || pop;
    ereq  = (win >= 0) && canis;
    egnt  = (ereq && g) ? 4'(1 << win) : 4'h0;
    evld  = pop ? 4'(1 << mq[0]) : 4'h0;
    check({tag, " gnt"}, 64'(mst.gnt), 64'(egnt));
    check({tag, " vld"}, 64'(mst.vld), 64'(evld));
    check({tag, " req"}, 64'(bank.req[0]), 64'(ereq));
    check({tag, " inf"}, 64'(inflight), 64'(mq.size()));
    check({tag, " err"}, 64'(err), 64'(merr));
    check({tag, " rdata"}, 64'(mst.rdata), 64'(rd));
    if (win >= 0)
      check({tag, " data"}, 64'(bank.data[0]), 64'(dv[win]));
    if (r) begin
      mq.delete();
      mptr = 0;
      merr = 0;
    end else begin
      if (v && mq.size() == 0) merr = 1;
      if (pop) void'(mq.pop_front());
      if (ereq && g) begin
        mq.push_back(win);
        mptr = (win + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst req gnt vld | e_gnt e_vld e_req e_inf e_err
    tbl.push_back('{0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 2'd0, 0});
    // rotation, responses one cycle behind
    tbl.push_back('{0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 2'd0, 0});
    tbl.push_back('{0, 4'hF, 1, 1, 4'h2, 4'h1, 1, 2'd1, 0});
    tbl.push_back('{0, 4'hF, 1, 1, 4'h4, 4'h2, 1, 2'd1, 0});
    tbl.push_back('{0, 4'hF, 1, 1, 4'h8, 4'h4, 1, 2'd1, 0});
    tbl.push_back('{0, 4'hF, 1, 1, 4'h1, 4'h8, 1, 2'd1, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 4'h0, 4'h1, 0, 2'd1, 0});
    // fill to MaxOutstanding, then pop frees a slot
    tbl.push_back('{0, 4'hF, 1, 0, 4'h2, 4'h0, 1, 2'd0, 0});
    tbl.push_back('{0, 4'hF, 1, 0, 4'h4, 4'h0, 1, 2'd1, 0});
    tbl.push_back('{0, 4'hF, 1, 0, 4'h0, 4'h0, 0, 2'd2, 0});
    tbl.push_back('{0, 4'hF, 1, 1, 4'h8, 4'h2, 1, 2'd2, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 4'h0, 4'h4, 0, 2'd2, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 4'h0, 4'h8, 0, 2'd1, 0});
    // ptr to 2, then stall with gnt_i low
    tbl.push_back('{0, 4'h2, 1, 0, 4'h2, 4'h0, 1, 2'd0, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 4'h0, 4'h2, 0, 2'd1, 0});
    tbl.push_back('{0, 4'hA, 0, 0, 4'h0, 4'h0, 1, 2'd0, 0});
    tbl.push_back('{0, 4'hA, 0, 0, 4'h0, 4'h0, 1, 2'd0, 0});
    tbl.push_back('{0, 4'hA, 0, 0, 4'h0, 4'h0, 1, 2'd0, 0});
    tbl.push_back('{0, 4'hA, 1, 0, 4'h8, 4'h0, 1, 2'd0, 0});
    tbl.push_back('{0, 4'hA, 1, 1, 4'h2, 4'h8, 1, 2'd1, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 4'h0, 4'h2, 0, 2'd1, 0});
    // response while empty, sticky error, reset
    tbl.push_back('{0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 2'd0, 0});
    tbl.push_back('{0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 2'd0, 1});
    tbl.push_back('{0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 2'd0, 1});
    tbl.push_back('{1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 2'd0, 1});
    tbl.push_back('{0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 2'd0, 0});
    // reset with two outstanding
    tbl.push_back('{0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 2'd0, 0});
    tbl.push_back('{0, 4'hF, 1, 0, 4'h2, 4'h0, 1, 2'd1, 0});
    tbl.push_back('{1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 2'd2, 0});
    tbl.push_back('{0, 4'hF, 1, 0, 4'h1, 4'h0, 1, 2'd0, 0});
    tbl.push_back('{0, 4'h0, 0, 1, 4'h0, 4'h1, 0, 2'd1, 0});

    drive(1'b1, 4'h0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // bank latency 3: masters 2 then 0 answered in order
    apply("lat0", '{0, 4'h4, 1, 0, 4'h4, 4'h0, 1, 2'd0, 0});
    apply("lat1", '{0, 4'h1, 1, 0, 4'h1, 4'h0, 1, 2'd1, 0});
    apply("lat2", '{0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 2'd2, 0});
    apply("lat3", '{0, 4'h0, 0, 1, 4'h0, 4'h4, 0, 2'd2, 0});
    apply("lat4", '{0, 4'h0, 0, 1, 4'h0, 4'h1, 0, 2'd1, 0});
    apply("lat5", '{0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 2'd0, 0});

    drive(1'b1, 4'h0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    mq.delete();
    mptr = 0;
    merr = 0;
    for (int c = 0; c < 600; c++) model_cycle(c);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
